// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus owner encoding and active-low grant levels.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      BUS_OWNER_IF  = 2'd0,
      BUS_OWNER_MEM = 2'd1,
      BUS_OWNER_DMA = 2'd2,
      BUS_OWNER_DBG = 2'd3
   } BusOwnerBus;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first active-high requester after the current owner, wrapping 3 -> 0.
module rr_pick
   import bus_arbiter_pkg::*;
(
   input  logic [3:0] req_i,
   input  BusOwnerBus owner_i,
   output BusOwnerBus nxt_o,
   output logic       found_o
);

   // Scan farthest offset first so the nearest requester is the last to win.
   always_comb begin
      found_o = 1'b0;
      nxt_o   = owner_i;
      for (int k = 3; k >= 1; k--) begin
         if (req_i[2'(owner_i + 2'(k))]) begin
            found_o = 1'b1;
            nxt_o   = BusOwnerBus'(2'(owner_i + 2'(k)));
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with parking, hold-limit
// preemption that never interrupts a strobed transfer, and registered grants.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   input  logic       m0_as_,
   input  logic       m1_as_,
   input  logic       m2_as_,
   input  logic       m3_as_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       preempt
);

   BusOwnerBus       owner_q, owner_d, nxt;
   logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
   logic             pre_q, pre_d, found, hold_hit;
   logic [3:0]       req, xfer;

   assign req  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign xfer = ~{m3_as_, m2_as_, m1_as_, m0_as_};

   rr_pick u_pick (
      .req_i  (req),
      .owner_i(owner_q),
      .nxt_o  (nxt),
      .found_o(found)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= BUS_OWNER_IF;
         hold_q  <= '0;
         pre_q   <= 1'b0;
      end else begin
         owner_q <= owner_d;
         hold_q  <= hold_d;
         pre_q   <= pre_d;
      end
   end

   assign hold_inc = &hold_q ? hold_q : hold_q + CNT_W'(1);
   assign hold_hit = (HOLD_MAX != 0) && (int'(hold_q) >= HOLD_MAX - 1);

   // A released bus moves on or parks; a held bus is only taken between transfers.
   always_comb begin
      owner_d = owner_q;
      hold_d  = '0;
      pre_d   = 1'b0;
      if (!req[owner_q]) begin
         owner_d = found ? nxt : owner_q;
      end else if (found && hold_hit && !xfer[owner_q]) begin
         owner_d = nxt;
         pre_d   = 1'b1;
      end else begin
         hold_d = hold_inc;
      end
   end

   always_comb begin
      m0_grnt_ = (owner_q == BUS_OWNER_IF)  ? ENABLE_ : DISABLE_;
      m1_grnt_ = (owner_q == BUS_OWNER_MEM) ? ENABLE_ : DISABLE_;
      m2_grnt_ = (owner_q == BUS_OWNER_DMA) ? ENABLE_ : DISABLE_;
      m3_grnt_ = (owner_q == BUS_OWNER_DBG) ? ENABLE_ : DISABLE_;
      owner    = owner_q;
      preempt  = pre_q;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a cycle-level model.
module tb_bus_arbiter;

   localparam int HM = 4;
   localparam int CMAX = 7;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_n, as_n, grnt_n;
   logic [1:0] owner;
   logic       preempt;

   int checks = 0;
   int errors = 0;
   int m_own = 0;
   int m_cnt = 0;
   bit m_pre = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter #(.HOLD_MAX(HM), .CNT_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .m0_req_ (req_n[0]),
      .m1_req_ (req_n[1]),
      .m2_req_ (req_n[2]),
      .m3_req_ (req_n[3]),
      .m0_as_  (as_n[0]),
      .m1_as_  (as_n[1]),
      .m2_as_  (as_n[2]),
      .m3_as_  (as_n[3]),
      .m0_grnt_(grnt_n[0]),
      .m1_grnt_(grnt_n[1]),
      .m2_grnt_(grnt_n[2]),
      .m3_grnt_(grnt_n[3]),
      .owner   (owner),
      .preempt (preempt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Active-high request and strobe vectors.
   task automatic drive(input logic [3:0] req, input logic [3:0] as_hi);
      req_n = ~req;
      as_n  = ~as_hi;
   endtask

   task automatic model_step();
      int nxt = -1;
      int old = m_cnt;
      for (int k = 1; k < 4; k++)
         if (nxt < 0 && !req_n[(m_own + k) % 4]) nxt = (m_own + k) % 4;
      m_pre = 1'b0;
      if (req_n[m_own]) begin
         if (nxt >= 0) m_own = nxt;
         m_cnt = 0;
      end else if (nxt >= 0 && old >= HM - 1 && as_n[m_own]) begin
         m_own = nxt;
         m_cnt = 0;
         m_pre = 1'b1;
      end else begin
         m_cnt = (old == CMAX) ? CMAX : old + 1;
      end
   endtask

   task automatic cmp_model(input string tag);
      logic [3:0] eg;
      eg = ~(4'b0001 << m_own);
      chk({tag, " owner"}, owner, m_own);
      chk({tag, " grnt"}, grnt_n, eg);
      chk({tag, " preempt"}, preempt, m_pre);
   endtask

   task automatic cyc(input string tag);
      model_step();
      @(posedge clk);
      #1;
      cmp_model(tag);
   endtask

   initial begin
      reset = 1'b0;
      drive(4'b0000, 4'b0000);
      #22;
      reset = 1'b1;
      #1;
      chk("rst owner", owner, 0);
      chk("rst grnt", grnt_n, 4'b1110);
      chk("rst preempt", preempt, 0);
      chk("rst hold", dut.hold_q, 0);
      @(negedge clk);
      for (int i = 0; i < 20; i++) cyc("idle");

      for (int i = 0; i < 5; i++) cyc("pre_m1");
      drive(4'b0010, 4'b0000);
      cyc("m1 req");
      chk("m1 granted", owner, 1);
      for (int i = 0; i < 3; i++) cyc("m1 hold");
      drive(4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) cyc("m1 park");
      chk("m1 parked", grnt_n, 4'b1101);

      drive(4'b0001, 4'b0000);
      cyc("to m0");
      chk("m0 own", owner, 0);
      drive(4'b1110, 4'b0000);
      cyc("rr m1");
      chk("rr first m1", owner, 1);
      drive(4'b1100, 4'b0000);
      cyc("rr m2");
      chk("rr then m2", owner, 2);
      drive(4'b1001, 4'b0000);
      cyc("rr m3");
      chk("rr then m3", owner, 3);
      drive(4'b0001, 4'b0000);
      cyc("rr m0");
      chk("rr wrap m0", owner, 0);

      drive(4'b0100, 4'b0000);
      cyc("to m2");
      drive(4'b1100, 4'b0000);
      for (int i = 0; i < 3; i++) cyc("contend");
      chk("no early preempt", owner, 2);
      cyc("preempt edge");
      chk("preempt owner", owner, 3);
      chk("preempt pulse", preempt, 1);
      drive(4'b1000, 4'b0000);
      cyc("pulse end");
      chk("preempt single", preempt, 0);

      drive(4'b0100, 4'b0000);
      cyc("to m2 again");
      drive(4'b1100, 4'b0100);
      for (int i = 0; i < 10; i++) cyc("strobe hold");
      chk("strobe kept", owner, 2);
      drive(4'b1100, 4'b0000);
      cyc("strobe end");
      chk("deferred preempt", owner, 3);
      chk("deferred pulse", preempt, 1);

      drive(4'b0100, 4'b0000);
      cyc("to m2 xfer");
      drive(4'b0100, 4'b0100);
      cyc("m2 xfer");
      #3;
      reset = 1'b0;
      #1;
      chk("async grnt", grnt_n, 4'b1110);
      chk("async owner", owner, 0);
      chk("async hold", dut.hold_q, 0);
      m_own = 0;
      m_cnt = 0;
      m_pre = 1'b0;
      drive(4'b0000, 4'b0000);
      @(negedge clk);
      reset = 1'b1;

      drive(4'b0001, 4'b0000);
      for (int i = 0; i < 12; i++) cyc("sat hold");
      chk("sat count", dut.hold_q, CMAX);
      drive(4'b0011, 4'b0000);
      cyc("sat preempt");
      chk("sat preempt owner", owner, 1);

      for (int i = 0; i < 2000; i++) begin
         logic [3:0] r, a;
         r = 4'($urandom);
         if ($urandom_range(3) == 0) r[m_own] = 1'b1;
         a = 4'b0000;
         if ($urandom_range(2) == 0) a[m_own] = 1'b1;
         drive(r, a);
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Four-master round-robin arbiter for the shared system bus. The CPU instruction-fetch port, the CPU memory-access port and two further masters (DMA, debug) request the bus through it. It owns the registered grant and parks the bus on its last owner. A hold-limit counter keeps one master from starving the others, and it never takes the bus from a master in the middle of a transfer.

## Interface
Parameters:
- `HOLD_MAX`, default 16: cycles an owner may keep the bus while others wait before it is preempted. 0 disables preemption.
- `CNT_W`, default 5: hold counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- `clk`  in  1: system clock. Every register updates on the rising edge.
- `reset`  in  1: reset, asynchronous and active-low.
- `m0_req_` .. `m3_req_`  in  1 each: bus request, active-low. m0 is instruction fetch, m1 is CPU memory access, m2 is DMA, m3 is debug.
- `m0_as_` .. `m3_as_`  in  1 each: address strobe from each master, active-low. Low means a transfer is in flight.
- `m0_grnt_` .. `m3_grnt_`  out  1 each: bus grant, active-low. Exactly one is low at all times out of reset.
- `owner`  out  2: index of the current owner. Drives the external address/data muxes.
- `preempt`  out  1: one-cycle high pulse in the cycle after a forced ownership change.

## Operation
- State registers:
  - `owner` (2 bits)
  - `hold_cnt` (CNT_W bits, saturating)
  - `preempt`
- Grant decode: `mN_grnt_` = !(owner == N). It is a pure decode of the `owner` register, so grants are glitch-free.
- Each cycle the arbiter evaluates `nxt` = the first requesting master in the order owner+1, owner+2, owner+3 (mod 4). The search wraps from 3 to 0.
- Case A, owner not requesting (`m[owner]_req_` = 1):
  - If `nxt` exists: owner <= nxt, hold_cnt <= 0.
  - Otherwise: owner is unchanged (parked) and hold_cnt <= 0.
- Case B, owner requesting and no other requester: owner is unchanged; hold_cnt increments, saturating at all-ones.
- Case C, owner requesting and another master requesting:
  - hold_cnt increments.
  - If HOLD_MAX != 0, and hold_cnt >= HOLD_MAX-1, and `m[owner]_as_` = 1: owner <= nxt, hold_cnt <= 0, preempt <= 1.
  - With `m[owner]_as_` = 0, the grant is never revoked. Preemption is deferred to the first cycle with as_ high.
- preempt <= 0 in every other cycle.
- Masters hold req_ low until they see their grant low, and start a transfer (as_ low) only while granted. A master that loses its grant while still requesting must wait to be granted again.
- Simultaneous release and new requests resolve through the round-robin order above. The previous owner has lowest priority.

## Timing
- Reset values:
  - owner = 0, so m0_grnt_ = 0 and m1..m3_grnt_ = 1.
  - hold_cnt = 0.
  - preempt = 0.
- Reset is asynchronous. If asserted mid-transfer, the grant returns to m0 immediately and any transfer in flight is abandoned. Masters are reset by the same signal.
- Grant latency: a request seen at edge k with the bus free or parked elsewhere appears as grant low after edge k+1, i.e. 1 cycle. The parked owner sees 0 cycles of latency.
- Handover: the owner raises req_ at edge k and the next requester is granted after edge k+1. There is no dead cycle and no overlap of grants.
- Preemption fires at the first edge where hold_cnt >= HOLD_MAX-1 with as_ high and a competitor requesting. That is HOLD_MAX cycles of contended ownership at minimum.
- The counter saturates and does not wrap.

## Structure
- The shared bus header carries:
  - `BusOwnerBus` [1:0]
  - `BUS_OWNER_IF`=0, `BUS_OWNER_MEM`=1, `BUS_OWNER_DMA`=2, `BUS_OWNER_DBG`=3
  - `ENABLE_`/`DISABLE_` active-low constants
- Sub-module `rr_pick`: combinational round-robin search. Inputs are a 4-bit active-high request vector and the current owner. Outputs are `nxt` and a `found` flag. It is reused by future interrupt priority logic.

## Test plan
- Reset, then no requests: owner=0, only m0_grnt_=0, preempt=0 for 20 cycles.
- m1_req_ low at cycle 5 with m0 idle: m1_grnt_=0 from cycle 6 and owner=1; m1 releases at cycle 9, and the bus stays parked on m1.
- Owner m0 releases while m1, m2 and m3 all request: grant goes to m1. Successive releases then give m2, m3, m0.
- HOLD_MAX=4, m2 holds req_ with as_ high and m3 requests: m3 is granted 4 cycles after contention begins, with a single-cycle preempt pulse.
- The same case with m2 as_ low for 10 cycles: there is no preemption during the strobe. m3 is granted one cycle after m2_as_ rises.
- Reset asserted while m2 owns the bus mid-transfer: m0_grnt_ goes low asynchronously, owner=0 and hold_cnt=0.
